// File: rtl/butterfly_type2_inv.sv
// rtl/butterfly_type2_inv.sv - inverse type-2 radix-2 butterfly, 2-stage elastic pipeline
// Optional macro BUTTERFLY_INV_ROUND_EN: round-half-up with saturation instead of truncation.
module butterfly_type2_inv #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_first,
    input  logic [DATA_WIDTH-1:0] s_real,
    input  logic [DATA_WIDTH-1:0] s_imag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_real0,
    output logic [DATA_WIDTH-1:0] m_imag0,
    output logic [DATA_WIDTH-1:0] m_real1,
    output logic [DATA_WIDTH-1:0] m_imag1,
    output logic                  pair_err
);

    localparam int W = DATA_WIDTH;

    typedef enum logic {
        WAIT_Y0 = 1'b0,
        WAIT_Y1 = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0] r_h_real;
    logic [W-1:0] r_h_imag;
    logic         r_s1_valid;
    logic [W:0]   r_sr;
    logic [W:0]   r_si;
    logic [W:0]   r_dr;
    logic [W:0]   r_di;
    logic         r_s2_valid;
    logic [W-1:0] r_real0;
    logic [W-1:0] r_imag0;
    logic [W-1:0] r_real1;
    logic [W-1:0] r_imag1;
    logic         r_pair_err;

    logic       w_s2_adv;
    logic       w_s1_free;
    logic       w_in_xfer;
    logic       w_pair_load;
    logic       w_hold_load;
    logic       w_resync;
    logic [W:0] w_sr;
    logic [W:0] w_si;
    logic [W:0] w_dr;
    logic [W:0] w_di;

    function automatic logic [W-1:0] half(input logic [W:0] x);
`ifdef BUTTERFLY_INV_ROUND_EN
        logic [W+1:0] t;
        logic [W:0]   q;
        t = {x[W], x} + (W+2)'(1);
        q = t[W+1:1];
        // Only the positive edge can overflow here; the negative clamp is kept for symmetry.
        if (q[W] != q[W-1]) begin
            half = q[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            half = q[W-1:0];
        end
`else
        half = x[W:1];
`endif
    endfunction

    // Stage 1 may move forward when stage 2 is empty or emptying this cycle.
    assign w_s2_adv    = en & r_s1_valid & (~r_s2_valid | m_ready);
    assign w_s1_free   = ~r_s1_valid | w_s2_adv;
    assign s_ready     = rst_n & en & ((r_state == WAIT_Y0) | w_s1_free);
    assign w_in_xfer   = en & s_valid & s_ready;
    assign w_resync    = w_in_xfer & (r_state == WAIT_Y1) & s_first;
    assign w_pair_load = w_in_xfer & (r_state == WAIT_Y1) & ~s_first;
    assign w_hold_load = w_in_xfer & ((r_state == WAIT_Y0) | s_first);

    // Y0 comes from the hold register, Y1 is the sample on the input right now.
    assign w_sr = {r_h_real[W-1], r_h_real} + {s_real[W-1], s_real};
    assign w_si = {r_h_imag[W-1], r_h_imag} + {s_imag[W-1], s_imag};
    assign w_dr = {r_h_imag[W-1], r_h_imag} - {s_imag[W-1], s_imag};
    assign w_di = {s_real[W-1], s_real} - {r_h_real[W-1], r_h_real};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_Y0: if (w_in_xfer) w_state_nxt = WAIT_Y1;
            WAIT_Y1: if (w_pair_load) w_state_nxt = WAIT_Y0;
            default: w_state_nxt = WAIT_Y0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_Y0;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_real   <= '0;
            r_h_imag   <= '0;
            r_s1_valid <= 1'b0;
            r_sr       <= '0;
            r_si       <= '0;
            r_dr       <= '0;
            r_di       <= '0;
            r_s2_valid <= 1'b0;
            r_real0    <= '0;
            r_imag0    <= '0;
            r_real1    <= '0;
            r_imag1    <= '0;
            r_pair_err <= 1'b0;
        end else if (en) begin
            if (w_hold_load) begin
                r_h_real <= s_real;
                r_h_imag <= s_imag;
            end
            if (w_resync) begin
                r_pair_err <= 1'b1;
            end
            if (w_pair_load) begin
                r_sr <= w_sr;
                r_si <= w_si;
                r_dr <= w_dr;
                r_di <= w_di;
            end
            r_s1_valid <= w_pair_load | (r_s1_valid & ~w_s2_adv);
            if (w_s2_adv) begin
                r_real0 <= half(r_sr);
                r_imag0 <= half(r_si);
                r_real1 <= half(r_dr);
                r_imag1 <= half(r_di);
            end
            r_s2_valid <= w_s2_adv | (r_s2_valid & ~m_ready);
        end
    end

    assign m_valid  = r_s2_valid;
    assign m_real0  = r_real0;
    assign m_imag0  = r_imag0;
    assign m_real1  = r_real1;
    assign m_imag1  = r_imag1;
    assign pair_err = r_pair_err;

endmodule
